// File: rtl/membank_stream_port.sv
// membank_stream_port: DMA-style streaming engine driving one memory-bank RAM port.
//   Read jobs fetch consecutive words into a 2-entry FIFO feeding m_*; write jobs
//   take s_* words and write them one cycle later to consecutive addresses.
// Latency: first read word on m_valid 2 cycles after the first ram_rd; write lands
//   the cycle after its s_valid/s_ready handshake. Full rate (1 word/cycle) both ways.
// Backpressure: m_ready low throttles ram_rd so buffered + in-flight never exceeds
//   the FIFO; s_ready is high only in WR_RUN while words remain and no abort is seen.
// Ports: HCLK/HRESETn clock and async active-low reset; cfg_* job control;
//   busy/done/done_err status; ram_* bank port; m_* output stream; s_* input stream.
module membank_stream_port #(
  parameter int RAM_ADDR_W = 10,
  parameter int RAM_DATA_W = 32,
  parameter int BYTE_W     = RAM_DATA_W / 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cfg_start,
  input  logic                  cfg_wr,
  input  logic [RAM_ADDR_W-1:0] cfg_addr,
  input  logic [RAM_ADDR_W:0]   cfg_len,
  input  logic                  cfg_abort,
  output logic                  busy,
  output logic                  done,
  output logic                  done_err,
  output logic                  ram_rd,
  output logic                  ram_wr,
  output logic [BYTE_W-1:0]     ram_wmask,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [RAM_DATA_W-1:0] ram_wdata,
  input  logic [RAM_DATA_W-1:0] ram_rdata,
  output logic                  m_valid,
  output logic [RAM_DATA_W-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  input  logic                  s_valid,
  input  logic [RAM_DATA_W-1:0] s_data,
  output logic                  s_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_RUN, S_RD_DRAIN, S_WR_RUN, S_DONE
  } state_t;

  localparam logic [RAM_ADDR_W-1:0] ONE_A = 1;
  localparam logic [RAM_ADDR_W:0]   ONE_L = 1;

  state_t                  state_q, state_d;
  logic [RAM_ADDR_W-1:0]   ptr_q, ptr_d;
  logic [RAM_ADDR_W:0]     rem_q, rem_d;
  logic                    err_q, err_d;
  logic                    inflight_q, inflight_d;
  logic                    infl_last_q, infl_last_d;
  logic                    wr_pend_q, wr_pend_d;
  logic [RAM_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [RAM_DATA_W-1:0]   wr_dat_q, wr_dat_d;

  // 2-entry read FIFO; the last-word tag travels with each entry
  logic [RAM_DATA_W-1:0]   fifo_dat_q [2];
  logic                    fifo_last_q [2];
  logic                    fifo_rd_q, fifo_wr_q;
  logic [1:0]              fifo_cnt_q;

  logic       active, abort, pop, push, issue, s_hs, flush;
  logic [2:0] occ, lim;

  assign active = (state_q != S_IDLE) && (state_q != S_DONE);
  assign abort  = cfg_abort && active;

  assign m_valid = (fifo_cnt_q != 2'd0);
  assign m_data  = fifo_dat_q[fifo_rd_q];
  assign m_last  = fifo_last_q[fifo_rd_q];
  assign pop     = m_valid && m_ready;
  assign push    = inflight_q;

  // Issue only if the word will have a FIFO slot when it returns next cycle
  assign occ   = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
  assign lim   = 3'd2 + {2'b00, pop};
  assign issue = (state_q == S_RD_RUN) && !cfg_abort && (occ < lim);

  assign s_ready = (state_q == S_WR_RUN) && (rem_q != '0) && !cfg_abort;
  assign s_hs    = s_valid && s_ready;

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign done_err  = err_q;
  assign ram_rd    = issue;
  assign ram_wr    = wr_pend_q;
  assign ram_wmask = {BYTE_W{wr_pend_q}};
  assign ram_addr  = wr_pend_q ? wr_addr_q : (issue ? ptr_q : '0);
  assign ram_wdata = wr_pend_q ? wr_dat_q : '0;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    err_d       = err_q;
    wr_pend_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_dat_d    = wr_dat_q;
    flush       = 1'b0;
    inflight_d  = issue;
    infl_last_d = issue && (rem_q == ONE_L);
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          ptr_d = cfg_addr;
          rem_d = cfg_len;
          err_d = 1'b0;
          if (cfg_len == '0) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (cfg_wr) begin
            state_d = S_WR_RUN;
          end else begin
            state_d = S_RD_RUN;
          end
        end
      end
      S_RD_RUN: begin
        if (issue) begin
          ptr_d = ptr_q + ONE_A;
          rem_d = rem_q - ONE_L;
          if (rem_q == ONE_L) state_d = S_RD_DRAIN;
        end
      end
      S_RD_DRAIN: begin
        // Leave as soon as the final word is being popped
        if (!inflight_q && ((fifo_cnt_q == 2'd0) || ((fifo_cnt_q == 2'd1) && pop)))
          state_d = S_DONE;
      end
      S_WR_RUN: begin
        if (s_hs) begin
          wr_pend_d = 1'b1;
          wr_addr_d = ptr_q;
          wr_dat_d  = s_data;
          ptr_d     = ptr_q + ONE_A;
          rem_d     = rem_q - ONE_L;
        end
        // Final write is on the port this cycle
        if (wr_pend_q && (rem_q == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_DONE;
      err_d      = 1'b1;
      wr_pend_d  = 1'b0;
      inflight_d = 1'b0;
      flush      = 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_dat_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      inflight_q  <= inflight_d;
      infl_last_q <= infl_last_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_dat_q    <= wr_dat_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      fifo_dat_q[0]  <= '0;
      fifo_dat_q[1]  <= '0;
      fifo_last_q[0] <= 1'b0;
      fifo_last_q[1] <= 1'b0;
      fifo_rd_q      <= 1'b0;
      fifo_wr_q      <= 1'b0;
      fifo_cnt_q     <= 2'd0;
    end else if (flush) begin
      fifo_rd_q  <= 1'b0;
      fifo_wr_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        fifo_dat_q[fifo_wr_q]  <= ram_rdata;
        fifo_last_q[fifo_wr_q] <= infl_last_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) fifo_rd_q <= ~fifo_rd_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_membank_stream_port.sv
// Directed bench for membank_stream_port with a behavioural bank RAM and a
// negedge monitor logging strobes, stream handshakes and done pulses.
module tb_membank_stream_port;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        cfg_start = 1'b0, cfg_wr = 1'b0, cfg_abort = 1'b0;
  logic [9:0]  cfg_addr = '0;
  logic [10:0] cfg_len = '0;
  logic        busy, done, done_err, ram_rd, ram_wr, m_valid, m_last, s_ready;
  logic [3:0]  ram_wmask;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata, m_data;
  logic [31:0] ram_rdata = '0;
  logic        m_ready = 1'b0, s_valid = 1'b0;
  logic [31:0] s_data = '0;

  always #5 HCLK = ~HCLK;

  membank_stream_port #(.RAM_ADDR_W(10), .RAM_DATA_W(32), .BYTE_W(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .cfg_start(cfg_start), .cfg_wr(cfg_wr),
    .cfg_addr(cfg_addr), .cfg_len(cfg_len), .cfg_abort(cfg_abort), .busy(busy),
    .done(done), .done_err(done_err), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_wmask(ram_wmask), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .m_ready(m_ready), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready));

  // Bank model: registered read, preloaded once while reset is first held
  logic [31:0] mem [0:1023];
  logic        loaded = 1'b0;
  always @(posedge HCLK) begin
    if (!loaded) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i >= 16 && i < 20) ? 32'hA0 + 32'(i - 16) : 32'h0;
      loaded <= 1'b1;
    end else begin
      if (ram_rd) ram_rdata <= mem[ram_addr];
      if (ram_wr) mem[ram_addr] <= ram_wdata;
    end
  end

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  logic [9:0]  rd_addr [$];
  int          rd_cyc  [$];
  logic [9:0]  wr_addr [$];
  logic [31:0] wr_dat  [$];
  logic [3:0]  wr_mask [$];
  int          wr_cyc  [$];
  logic [31:0] hs_dat  [$];
  logic        hs_last [$];
  int          hs_cyc  [$];
  int          done_cyc[$];
  logic        done_e  [$];
  int          viol = 0;
  logic        clr_req = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_dat = '0;
  logic        prev_last = 1'b0;

  always @(negedge HCLK) begin
    if (clr_req) begin
      rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_dat.delete();
      wr_mask.delete(); wr_cyc.delete(); hs_dat.delete(); hs_last.delete();
      hs_cyc.delete(); done_cyc.delete(); done_e.delete();
    end
    if (HRESETn) begin
      if (ram_rd) begin rd_addr.push_back(ram_addr); rd_cyc.push_back(cyc); end
      if (ram_wr) begin
        wr_addr.push_back(ram_addr); wr_dat.push_back(ram_wdata);
        wr_mask.push_back(ram_wmask); wr_cyc.push_back(cyc);
      end
      if (m_valid && m_ready) begin
        hs_dat.push_back(m_data); hs_last.push_back(m_last); hs_cyc.push_back(cyc);
      end
      if (done) begin done_cyc.push_back(cyc); done_e.push_back(done_err); end
      if (ram_rd && ram_wr) viol <= viol + 1;
      if (!ram_wr && ram_wmask != 4'h0) viol <= viol + 1;
      if (prev_stall && m_valid && (m_data !== prev_dat || m_last !== prev_last)) viol <= viol + 1;
      if (rd_addr.size() - hs_dat.size() > 3) viol <= viol + 1;
    end
    prev_stall <= m_valid && !m_ready;
    prev_dat   <= m_data;
    prev_last  <= m_last;
  end

  int checks = 0;
  int errors = 0;
  int t0 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK); #1;
  endtask

  task automatic clr();
    clr_req = 1'b1;
    @(negedge HCLK); #1;
    clr_req = 1'b0;
    tick();
  endtask

  task automatic start(input logic w, input logic [9:0] a, input logic [10:0] l);
    cfg_wr = w; cfg_addr = a; cfg_len = l; cfg_start = 1'b1;
    t0 = cyc;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    while (done_cyc.size() == 0 && b < 100) begin tick(); b++; end
    tick();
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int b = 0;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1; s_data = d; #1;
    while (!s_ready && b < 20) begin tick(); b++; end
    tick();
    s_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_err", done_err, 0);    chk("rst_rd_wr", {ram_rd, ram_wr}, 0);
    chk("rst_ram", {ram_wmask, ram_addr, ram_wdata}, 0);
    chk("rst_m", {m_valid, m_last, m_data}, 0);
    chk("rst_s_ready", s_ready, 0);
    HRESETn = 1'b1;
    tick();

    // Read 4 words at full rate
    m_ready = 1'b1;
    clr();
    start(1'b0, 10'h010, 11'd4);
    wait_done();
    chk("rd1_count", rd_addr.size(), 4);
    chk("hs1_count", hs_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("rd1_addr", rd_addr[i], 32'h10 + i);
      chk("rd1_cyc", rd_cyc[i], t0 + 1 + i);
      chk("hs1_dat", hs_dat[i], 32'hA0 + i);
      chk("hs1_cyc", hs_cyc[i], t0 + 3 + i);
      chk("hs1_last", hs_last[i], (i == 3) ? 1 : 0);
    end
    chk("done1_count", done_cyc.size(), 1);
    chk("done1_cyc", done_cyc[0], t0 + 7);
    chk("done1_err", done_e[0], 0);
    chk("idle1_busy", busy, 0);

    // Same read with m_ready 1,0,0 repeating
    clr();
    m_ready = 1'b1;
    start(1'b0, 10'h010, 11'd4);
    for (int k = 1; k < 100 && done_cyc.size() == 0; k++) begin
      m_ready = (k % 3 == 0);
      tick();
    end
    m_ready = 1'b1;
    tick();
    chk("rd2_count", rd_addr.size(), 4);
    chk("hs2_count", hs_dat.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("hs2_dat", hs_dat[i], 32'hA0 + i);
      chk("hs2_last", hs_last[i], (i == 3) ? 1 : 0);
    end
    chk("done2_err", done_e[0], 0);

    // Write 3 words across the address wrap; gaps then back-to-back
    clr();
    start(1'b1, 10'h3FE, 11'd3);
    send(32'h11, 1);
    send(32'h22, 2);
    send(32'h33, 0);
    wait_done();
    chk("wr3_count", wr_addr.size(), 3);
    chk("wr3_addr0", wr_addr[0], 10'h3FE);
    chk("wr3_addr1", wr_addr[1], 10'h3FF);
    chk("wr3_addr2", wr_addr[2], 10'h000);
    chk("wr3_dat0", wr_dat[0], 32'h11);
    chk("wr3_dat1", wr_dat[1], 32'h22);
    chk("wr3_dat2", wr_dat[2], 32'h33);
    for (int i = 0; i < 3; i++) chk("wr3_mask", wr_mask[i], 4'hF);
    chk("wr3_b2b", wr_cyc[2] - wr_cyc[1], 1);
    chk("wr3_mem", mem[0], 32'h33);
    chk("wr3_no_rd", rd_addr.size(), 0);
    chk("done3_count", done_cyc.size(), 1);
    chk("done3_err", done_e[0], 0);

    // Zero-length job
    clr();
    start(1'b0, 10'h020, 11'd0);
    chk("len0_done", done, 1);
    chk("len0_err", done_err, 1);
    tick();
    chk("len0_done_pulse", done, 0);
    chk("len0_err_hold", done_err, 1);
    chk("len0_busy", busy, 0);
    chk("len0_no_strobes", rd_addr.size() + wr_addr.size(), 0);

    // Abort a stalled 16-word read
    clr();
    m_ready = 1'b0;
    start(1'b0, 10'h010, 11'd16);
    repeat (4) tick();
    chk("ab_mvalid_before", m_valid, 1);
    cfg_abort = 1'b1;
    tick();
    cfg_abort = 1'b0;
    chk("ab_done", done, 1);
    chk("ab_err", done_err, 1);
    chk("ab_mvalid", m_valid, 0);
    chk("ab_reads_le3", (rd_addr.size() <= 3) ? 1 : 0, 1);
    tick();
    chk("ab_idle", busy, 0);
    clr();
    m_ready = 1'b1;
    start(1'b0, 10'h012, 11'd2);
    chk("ab_err_clear", done_err, 0);
    wait_done();
    chk("ab_next_count", hs_dat.size(), 2);
    chk("ab_next_dat0", hs_dat[0], 32'hA2);
    chk("ab_next_dat1", hs_dat[1], 32'hA3);
    chk("ab_next_last", {hs_last[0], hs_last[1]}, 2'b01);
    chk("ab_next_err", done_e[0], 0);

    // Reset mid-write
    clr();
    start(1'b1, 10'h100, 11'd3);
    s_valid = 1'b1; s_data = 32'hDEADBEEF;
    tick();
    s_valid = 1'b0;
    chk("rstw_wr_live", ram_wr, 1);
    HRESETn = 1'b0;
    #1;
    chk("rstw_busy", busy, 0);
    chk("rstw_strobes", {ram_rd, ram_wr, ram_wmask}, 0);
    chk("rstw_bus", {ram_addr, ram_wdata}, 0);
    chk("rstw_s_ready", s_ready, 0);
    repeat (2) tick();
    HRESETn = 1'b1;
    repeat (3) tick();
    chk("rstw_idle", {busy, done, done_err}, 0);
    chk("rstw_no_write", wr_addr.size(), 0);
    chk("rstw_mem", mem[10'h100], 0);

    chk("protocol_violations", viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
